core_seq_ctrl: RTL
==================

# core_seq_ctrl

Multi-cycle sequencer for the RV32I core: owns the PC and the instruction-step state machine (fetch, decode, execute, memory, writeback) around the combinational ALU and decoder. Drives the instruction/data memory req/ack handshakes, the capture strobes for the IR, operand and ALU-result registers, and the register-file write enable. Consumes the ALU `br_taken` to select the next PC. Halts on illegal instructions or a memory timeout.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset
- `MEM_TIMEOUT`, 255, max cycles a memory request waits for ack before halting (1..65535)
- `clk` in 1 — core clock, all state on rising edge
- `rst_n` in 1 — asynchronous, active-low reset
- `imem_req` out 1 — instruction fetch request, address = `pc`
- `imem_ack` in 1 — fetch data valid this cycle
- `dmem_req` out 1 — data access request
- `dmem_we` out 1 — 1 = store, 0 = load; valid while `dmem_req`
- `dmem_ack` in 1 — data access complete
- `dec_load`, `dec_store`, `dec_rf_we`, `dec_illegal` in 1 each — decoder class flags, stable from DECODE through WB
- `br_taken` in 1 — ALU branch/jump decision, sampled in EXECUTE
- `br_target` in 32 — computed branch/jump target, sampled in EXECUTE
- `pc` out 32 — current PC
- `ir_we`, `opr_we`, `res_we` out 1 each — one-cycle capture strobes for IR, operand and ALU-result registers
- `rf_we` out 1 — register-file write enable
- `retire` out 1 — one-cycle pulse per completed instruction
- `state` out 3 — current state encoding
- `halted` out 1 — core stopped; `halt_cause` out 2 (0 none, 1 illegal, 2 imem timeout, 3 dmem timeout)

## Operation
- States: RESET, FETCH, DECODE, EXEC, MEM, WB, HALT.
- RESET: outputs idle; next FETCH unconditionally.
- FETCH: `imem_req`=1 until `imem_ack`; on ack `ir_we` pulses in the same cycle, next DECODE.
- DECODE: `opr_we`=1; `dec_illegal` → HALT with cause 1, else EXEC.
- EXEC: `res_we`=1; register `taken_q`←`br_taken` and `tgt_q`←`br_target`; `dec_load|dec_store` → MEM, else WB.
- MEM: `dmem_req`=1, `dmem_we`=`dec_store` until `dmem_ack`, then WB.
- WB: `rf_we`=`dec_rf_we`; `pc`←`taken_q ? tgt_q : pc+4` (mod 2^32, wraps 32'hFFFF_FFFC→0); `retire`=1; next FETCH.
- Timeout: wait counter clears on entry to FETCH/MEM and counts each cycle without ack; when it reaches `MEM_TIMEOUT` with no ack → HALT (cause 2 or 3), request dropped. Ack in the same cycle as the limit wins.
- HALT: all strobes/requests 0, `halted`=1, cause held; only reset exits.
- Acks outside FETCH/MEM are ignored.

## Timing
- Reset values: `pc`=`RESET_PC`, state RESET, all strobes/requests/`retire`/`halted` 0, `halt_cause` 0, `taken_q` 0.
- Reset assertion mid-step aborts immediately (asynchronous); any outstanding request is dropped.
- Strobes and requests are Moore outputs of state except `ir_we` (= FETCH & `imem_ack`).
- Min latency, zero-wait memory: ALU/branch instruction 4 cycles, load/store 5 cycles; each wait cycle adds 1.
- `pc` updates on the clock edge ending WB; new value visible in the following FETCH.

## Configuration
- `CORE_SEQ_PERF_EN`: when defined, adds outputs `cycle_cnt` (64-bit, +1 every cycle out of reset, frozen in HALT) and `instret_cnt` (64-bit, +1 per `retire`), both reset to 0 and wrapping. When undefined, neither the ports nor the counters exist.

## Structure
- Shared package `core_pkg`: state encoding constants, `halt_cause` codes, `RESET_PC` default.
- Sub-module `perf_counter` (64-bit enable-count register), instantiated twice only under `CORE_SEQ_PERF_EN`.

## Test plan
- Reset release, `imem_ack` tied 1, non-branch ALU ops → `retire` every 4 cycles, `pc` 0→4→8.
- Branch with `br_taken`=1, `br_target`=32'h100 at `pc`=8 → next FETCH at `pc`=32'h100; with `br_taken`=0 → 32'hC.
- Store with `dmem_ack` after 3 wait cycles → `dmem_req` high 4 cycles, `dmem_we`=1, retire at cycle 8 of the step.
- `MEM_TIMEOUT`=4, `imem_ack` never → HALT after 4 FETCH wait cycles, `halted`=1, `halt_cause`=2, `pc` unchanged.
- `dec_illegal`=1 in DECODE → HALT, cause 1, no `rf_we`/`retire`; assert `rst_n`=0 mid-MEM → `pc`=`RESET_PC`, `dmem_req`=0 the same cycle.
- `pc`=32'hFFFF_FFFC non-branch → wraps to 0; with `CORE_SEQ_PERF_EN`, `instret_cnt` matches `retire` count.

Source files
------------

// File: rtl/core_seq_ctrl_pkg.sv
// core_pkg: definitions shared by the RV32I multi-cycle sequencer.
//   state_e      - sequencer state encoding (also driven out on the `state` port)
//   halt_cause_e - codes reported on `halt_cause`
//   RESET_PC_DEFAULT / MEM_TIMEOUT_DEFAULT - parameter defaults for core_seq_ctrl
//   next_pc()    - PC selection applied at the end of writeback
package core_pkg;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    HC_NONE    = 2'd0,
    HC_ILLEGAL = 2'd1,
    HC_IMEM_TO = 2'd2,
    HC_DMEM_TO = 2'd3
  } halt_cause_e;

  localparam logic [31:0] RESET_PC_DEFAULT    = 32'h0000_0000;
  localparam int unsigned MEM_TIMEOUT_DEFAULT = 32'd255;

  // Taken branches/jumps go to the captured target, everything else falls
  // through; the +4 wraps naturally at 2^32.
  function automatic logic [31:0] next_pc(input logic        taken,
                                          input logic [31:0] target,
                                          input logic [31:0] cur_pc);
    logic [31:0] npc;
    if (taken) begin
      npc = target;
    end else begin
      npc = cur_pc + 32'd4;
    end
    return npc;
  endfunction

endpackage

// File: rtl/core_seq_ctrl_if.sv
// core_seq_ctrl_if: instruction/data memory request/acknowledge handshake.
//   imem_req - fetch request (address is the sequencer PC)
//   imem_ack - fetch data valid this cycle
//   dmem_req - data access request
//   dmem_we  - 1 = store, 0 = load; meaningful while dmem_req is high
//   dmem_ack - data access complete
// modport master: sequencer side; modport slave: memory side.
interface core_seq_ctrl_if;
  logic imem_req;
  logic imem_ack;
  logic dmem_req;
  logic dmem_we;
  logic dmem_ack;

  modport master (output imem_req, output dmem_req, output dmem_we,
                  input  imem_ack, input  dmem_ack);
  modport slave  (input  imem_req, input  dmem_req, input  dmem_we,
                  output imem_ack, output dmem_ack);
endinterface

// File: rtl/core_seq_ctrl_perf_counter.sv
// perf_counter: 64-bit free-running event counter, used by core_seq_ctrl
// only when CORE_SEQ_PERF_EN is defined.
//   clk, rst_n - clock and asynchronous active-low reset (clears to 0)
//   en_i       - count enable, +1 on each rising edge while high (wraps)
//   cnt_o      - current count
module perf_counter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en_i,
  output logic [63:0] cnt_o
);

  logic [63:0] cnt_q;

  // Enabled increment, wrapping at 2^64.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 64'd0;
    end else if (en_i) begin
      cnt_q <= cnt_q + 64'd1;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/core_seq_ctrl.sv
// core_seq_ctrl: multi-cycle instruction-step sequencer for the RV32I core.
// Owns the PC and steps FETCH -> DECODE -> EXEC -> [MEM] -> WB, halting on an
// illegal instruction or a memory request that waits MEM_TIMEOUT cycles.
// Parameters: RESET_PC (PC after reset), MEM_TIMEOUT (1..65535 wait cycles).
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   mem (master modport)  - imem/dmem req/ack handshakes
//   dec_load/store/rf_we/illegal - decoder class flags (stable DECODE..WB)
//   br_taken, br_target   - ALU branch decision/target, sampled in EXEC
//   pc                    - current PC
//   ir_we, opr_we, res_we - IR / operand / ALU-result capture strobes
//   rf_we, retire         - register-file write enable, retire pulse
//   state, halted, halt_cause - state encoding, halt flag and reason
// Optional: macro CORE_SEQ_PERF_EN adds cycle_cnt and instret_cnt (64-bit).
module core_seq_ctrl
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  core_seq_ctrl_if.master        mem,
  input  logic                   dec_load,
  input  logic                   dec_store,
  input  logic                   dec_rf_we,
  input  logic                   dec_illegal,
  input  logic                   br_taken,
  input  logic [31:0]            br_target,
  output logic [31:0]            pc,
  output logic                   ir_we,
  output logic                   opr_we,
  output logic                   res_we,
  output logic                   rf_we,
  output logic                   retire,
  output logic [2:0]             state,
  output logic                   halted,
  output logic [1:0]             halt_cause
`ifdef CORE_SEQ_PERF_EN
  ,
  output logic [63:0]            cycle_cnt,
  output logic [63:0]            instret_cnt
`endif
);

  // Wait counter value seen during the last permitted wait cycle.
  localparam logic [15:0] WAIT_LAST = 16'(MEM_TIMEOUT - 32'd1);

  state_e      state_q, state_d;
  logic [1:0]  cause_q, cause_d;
  logic [15:0] wait_q;
  logic [31:0] pc_q;
  logic        taken_q;
  logic [31:0] tgt_q;
  logic        imem_req_q, dmem_req_q, dmem_we_q;
  logic        opr_we_q, res_we_q, rf_we_q, retire_q, halted_q;
  logic        wait_last_s;

  assign wait_last_s = (wait_q == WAIT_LAST);

  // Next-state and halt-cause selection; an ack on the limit cycle wins.
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      ST_RESET: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (mem.imem_ack) begin
          state_d = ST_DECODE;
        end else if (wait_last_s) begin
          state_d = ST_HALT;
          cause_d = HC_IMEM_TO;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_DECODE: begin
        if (dec_illegal) begin
          state_d = ST_HALT;
          cause_d = HC_ILLEGAL;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (dec_load || dec_store) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        if (mem.dmem_ack) begin
          state_d = ST_WB;
        end else if (wait_last_s) begin
          state_d = ST_HALT;
          cause_d = HC_DMEM_TO;
        end else begin
          state_d = ST_MEM;
        end
      end
      ST_WB: begin
        state_d = ST_FETCH;
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        // Unreachable encoding: stop rather than run on corrupted state.
        state_d = ST_HALT;
      end
    endcase
  end

  // State, PC, branch capture and registered Moore outputs (decoded from the
  // state being entered so they line up with the new state).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RESET;
      cause_q    <= HC_NONE;
      wait_q     <= 16'd0;
      pc_q       <= RESET_PC;
      taken_q    <= 1'b0;
      tgt_q      <= 32'd0;
      imem_req_q <= 1'b0;
      dmem_req_q <= 1'b0;
      dmem_we_q  <= 1'b0;
      opr_we_q   <= 1'b0;
      res_we_q   <= 1'b0;
      rf_we_q    <= 1'b0;
      retire_q   <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      // Counts only while waiting in the same FETCH/MEM visit; any entry clears it.
      if ((state_d == state_q) && ((state_q == ST_FETCH) || (state_q == ST_MEM))) begin
        wait_q <= wait_q + 16'd1;
      end else begin
        wait_q <= 16'd0;
      end
      if (state_q == ST_EXEC) begin
        taken_q <= br_taken;
        tgt_q   <= br_target;
      end
      if (state_q == ST_WB) begin
        pc_q <= next_pc(taken_q, tgt_q, pc_q);
      end
      imem_req_q <= (state_d == ST_FETCH);
      dmem_req_q <= (state_d == ST_MEM);
      dmem_we_q  <= (state_d == ST_MEM) && dec_store;
      opr_we_q   <= (state_d == ST_DECODE);
      res_we_q   <= (state_d == ST_EXEC);
      rf_we_q    <= (state_d == ST_WB) && dec_rf_we;
      retire_q   <= (state_d == ST_WB);
      halted_q   <= (state_d == ST_HALT);
    end
  end

  // IR capture has to coincide with the fetch ack, so it is the one Mealy strobe.
  assign ir_we        = (state_q == ST_FETCH) && mem.imem_ack;
  assign mem.imem_req = imem_req_q;
  assign mem.dmem_req = dmem_req_q;
  assign mem.dmem_we  = dmem_we_q;
  assign opr_we       = opr_we_q;
  assign res_we       = res_we_q;
  assign rf_we        = rf_we_q;
  assign retire       = retire_q;
  assign halted       = halted_q;
  assign halt_cause   = cause_q;
  assign pc           = pc_q;
  assign state        = state_q;

`ifdef CORE_SEQ_PERF_EN
  perf_counter u_cycle_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (state_q != ST_HALT),
    .cnt_o (cycle_cnt)
  );

  perf_counter u_instret_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (retire_q),
    .cnt_o (instret_cnt)
  );
`endif

endmodule
